// File: rtl/ifu_fetch_engine.sv
// Instruction fetch unit: issues one word-aligned read at a time over a valid/ready bus,
// buffers the returned words in a small FIFO for the decoder and handles branch redirects.
module ifu_fetch_engine #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000,
    parameter int                    BUF_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  rsp_valid,
    output logic                  rsp_ready,
    input  logic [DATA_WIDTH-1:0] rsp_data,
    input  logic                  rsp_err,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] out_inst,
    output logic                  out_err
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP, S_HALT} state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] inst;
        logic                  err;
    } entry_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                  pend_q, pend_d;
    logic [ADDR_WIDTH-1:0] pend_pc_q, pend_pc_d;
    logic [CNT_W-1:0]      count_q;
    logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q;
    logic                  push, pop;
    logic [ADDR_WIDTH-1:0] redir_pc;
    entry_t                buf_mem [BUF_DEPTH];

    assign redir_pc  = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    assign req_addr  = fetch_pc_q;
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    assign out_pc    = out_valid ? buf_mem[rd_ptr_q].pc   : '0;
    assign out_inst  = out_valid ? buf_mem[rd_ptr_q].inst : '0;
    assign out_err   = out_valid ? buf_mem[rd_ptr_q].err  : 1'b0;

    // NOTE: every signal written here gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pend_d     = pend_q;
        pend_pc_d  = pend_pc_q;
        push       = 1'b0;
        req_valid  = 1'b0;
        rsp_ready  = 1'b0;
        unique case (state_q)
            S_REQ: begin
                // A redirect against a presented request is parked in pend_* so the bus stays stable.
                req_valid = !rst && ((count_q < DEPTH_C) || pend_q);
                if (req_valid && req_ready) begin
                    pend_d = 1'b0;
                    if (redirect_valid) begin
                        state_d    = S_DROP;
                        fetch_pc_d = redir_pc;
                    end else if (pend_q) begin
                        state_d    = S_DROP;
                        fetch_pc_d = pend_pc_q;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else if (redirect_valid) begin
                    if (req_valid) begin
                        pend_d    = 1'b1;
                        pend_pc_d = redir_pc;
                    end else begin
                        fetch_pc_d = redir_pc;
                    end
                end
            end
            S_WAIT: begin
                rsp_ready = !rst;
                if (redirect_valid) begin
                    fetch_pc_d = redir_pc;
                    state_d    = rsp_valid ? S_REQ : S_DROP;
                end else if (rsp_valid) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
                    state_d    = rsp_err ? S_HALT : S_REQ;
                end
            end
            S_DROP: begin
                rsp_ready = !rst;
                if (redirect_valid) fetch_pc_d = redir_pc;
                if (rsp_valid)      state_d    = S_REQ;
            end
            S_HALT: begin
                if (redirect_valid) begin
                    fetch_pc_d = redir_pc;
                    state_d    = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_REQ;
            fetch_pc_q <= RESET_PC;
            pend_q     <= 1'b0;
            pend_pc_q  <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pend_q     <= pend_d;
            pend_pc_q  <= pend_pc_d;
            if (redirect_valid) begin
                count_q  <= '0;
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // NOTE: storage is deliberately not reset; count_q alone says which entries are live.
    always_ff @(posedge clk) begin
        if (push) buf_mem[wr_ptr_q] <= '{pc: fetch_pc_q, inst: rsp_data, err: rsp_err};
    end

endmodule

// File: tb/tb_ifu_fetch_engine.sv
// Randomized bench for ifu_fetch_engine: a transaction-level model of the expected
// instruction stream, fetch address and bus handshakes is compared every cycle.
module tb_ifu_fetch_engine;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_pc;
    logic [DW-1:0] out_inst;
    logic          out_err;

    always #5 clk = ~clk;

    ifu_fetch_engine #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(32'h8000_0000), .BUF_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .out_err(out_err)
    );

    typedef struct {
        logic [AW-1:0] pc;
        logic [DW-1:0] inst;
        logic          err;
    } entry_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: expected decoder stream plus the memory side's view of the bus.
    entry_t        q[$];
    logic [AW-1:0] exp_pc;
    bit            halted;
    int            epoch = 0;
    bit            pres;
    int            pres_epoch;
    logic [AW-1:0] pres_addr;
    bit            busy;
    int            busy_epoch;
    logic [AW-1:0] busy_addr;
    logic [DW-1:0] busy_data;
    bit            busy_err;
    int            busy_delay;
    bit            chk_en = 0;

    int            p_req = 100, p_out = 100, p_redir = 0, p_err = 0, p_junk = 0;
    int            fixed_delay = 0;
    logic [AW-1:0] err_addr = 32'hFFFF_FFFF;

    task automatic model_reset();
        q.delete();
        exp_pc = 32'h8000_0000;
        halted = 0;
        pres   = 0;
        busy   = 0;
        epoch++;
    endtask

    function automatic logic [AW-1:0] pick_target();
        case ($urandom_range(5))
            0:       return 32'hFFFF_FFFC;
            1:       return 32'h8000_0003;
            2:       return 32'h8000_0100;
            3:       return 32'h8000_0200;
            default: return $urandom;
        endcase
    endfunction

    task automatic step(input bit redir, input logic [AW-1:0] rpc, input bit do_rst);
        bit            rd_v, rv, ov, was_busy;
        logic [AW-1:0] rd_pc, a;
        @(negedge clk);
        rst   = do_rst;
        rd_v  = redir;
        rd_pc = rpc;
        if (!redir && !do_rst && p_redir > 0 && $urandom_range(99) < p_redir) begin
            rd_v  = 1;
            rd_pc = pick_target();
        end
        redirect_valid = rd_v;
        redirect_pc    = rd_pc;
        req_ready      = ($urandom_range(99) < p_req);
        out_ready      = ($urandom_range(99) < p_out);
        if (busy) begin
            rsp_valid = (busy_delay == 0);
            rsp_data  = busy_data;
            rsp_err   = busy_err;
        end else begin
            rsp_valid = ($urandom_range(99) < p_junk);
            rsp_data  = $urandom;
            rsp_err   = 1'($urandom_range(1));
        end
        #1;
        if (chk_en) begin
            check("out_valid", out_valid, q.size() != 0);
            if (q.size() != 0) begin
                check("out_pc", out_pc, q[0].pc);
                check("out_inst", out_inst, q[0].inst);
                check("out_err", out_err, q[0].err);
            end else begin
                check("idle_out", {out_pc, out_inst}, '0);
                check("idle_err", out_err, 0);
            end
            if (do_rst) begin
                check("rst_req_valid", req_valid, 0);
                check("rst_rsp_ready", rsp_ready, 0);
            end else begin
                check("req_valid", req_valid, pres || (!halted && !busy && q.size() < DEPTH));
                check("rsp_ready", rsp_ready, busy);
                if (req_valid) check("req_addr", req_addr, pres ? pres_addr : exp_pc);
            end
        end
        rv = req_valid;
        ov = out_valid;
        @(posedge clk);
        if (do_rst) begin
            model_reset();
        end else begin
            was_busy = busy;
            if (ov && out_ready && q.size() > 0) void'(q.pop_front());
            if (rv) begin
                a = pres ? pres_addr : exp_pc;
                if (req_ready) begin
                    busy       = 1;
                    busy_epoch = pres ? pres_epoch : epoch;
                    busy_addr  = a;
                    busy_data  = $urandom;
                    busy_err   = (a == err_addr) || ($urandom_range(99) < p_err);
                    busy_delay = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(3));
                    pres       = 0;
                end else if (!pres) begin
                    pres       = 1;
                    pres_epoch = epoch;
                    pres_addr  = a;
                end
            end
            if (was_busy && rsp_valid) begin
                if (busy_epoch == epoch && !rd_v) begin
                    q.push_back('{busy_addr, busy_data, busy_err});
                    exp_pc = exp_pc + 32'd4;
                    if (busy_err) halted = 1;
                end
                busy = 0;
            end else if (was_busy && busy_delay > 0) begin
                busy_delay--;
            end
            if (rd_v) begin
                q.delete();
                exp_pc = {rd_pc[AW-1:2], 2'b00};
                halted = 0;
                epoch++;
            end
        end
    endtask

    initial begin
        rst = 1; redirect_valid = 0; redirect_pc = '0; req_ready = 0;
        rsp_valid = 0; rsp_data = '0; rsp_err = 0; out_ready = 0;
        model_reset();
        step(0, '0, 1);
        step(0, '0, 1);
        chk_en = 1;
        step(0, '0, 1);
        step(0, '0, 1);

        // Streaming with an always-ready memory and decoder.
        repeat (20) step(0, '0, 0);

        // Decoder stalls: FIFO fills and requests stop, then drains in order.
        p_out = 0;
        repeat (20) step(0, '0, 0);
        #1 check("full_no_req", req_valid, 0);
        check("full_out_valid", out_valid, 1);
        p_out = 100;
        repeat (20) step(0, '0, 0);

        // Redirect while a response is outstanding; stale word must be dropped.
        fixed_delay = 3;
        for (int i = 0; i < 50 && !busy; i++) step(0, '0, 0);
        check("wait_busy", busy, 1);
        step(1, 32'h8000_0100, 0);
        repeat (12) step(0, '0, 0);

        // Redirect against a request the memory is still refusing.
        fixed_delay = 0;
        p_req = 0;
        for (int i = 0; i < 50 && !pres; i++) step(0, '0, 0);
        check("wait_pres", pres, 1);
        step(1, 32'h8000_0040, 0);
        repeat (3) step(0, '0, 0);
        p_req = 100;
        repeat (10) step(0, '0, 0);

        // Access fault halts fetch until the next redirect.
        step(0, '0, 1);
        err_addr = 32'h8000_0008;
        repeat (15) step(0, '0, 0);
        #1 check("halt_no_req", req_valid, 0);
        err_addr = 32'hFFFF_FFFF;
        step(1, 32'h8000_0200, 0);
        repeat (8) step(0, '0, 0);

        // Address wrap and ignored low redirect bits.
        step(1, 32'hFFFF_FFFC, 0);
        repeat (8) step(0, '0, 0);
        step(1, 32'h8000_0003, 0);
        repeat (6) step(0, '0, 0);

        // Randomized traffic with occasional mid-run resets.
        fixed_delay = -1;
        for (int blk = 0; blk < 20; blk++) begin
            p_req   = 30 + int'($urandom_range(70));
            p_out   = 20 + int'($urandom_range(80));
            p_redir = int'($urandom_range(10));
            p_err   = int'($urandom_range(10));
            p_junk  = int'($urandom_range(10));
            for (int c = 0; c < 200; c++) step(0, '0, ($urandom_range(499) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ifu_fetch_engine.md
Name: ifu_fetch_engine

Overview:
- Multi-cycle instruction fetch unit. Replaces the combinational DPI fetch with a valid/ready memory request/response bus.
- Buffers fetched instructions in a parametrised FIFO ahead of the decoder.
- Handles branch redirects, including discarding an in-flight stale response.
- Sits between the PC/redirect source (EXU) and the IDU; all buffering and flow control live here.

Parameters:
- ADDR_WIDTH, 32, fetch address / PC width
- DATA_WIDTH, 32, instruction word width
- RESET_PC, 32'h8000_0000, first fetch address after reset
- BUF_DEPTH, 4, instruction FIFO entries; power of two, at least 2

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- redirect_valid  in  1  single-cycle pulse: flush and restart fetch at redirect_pc
- redirect_pc  in  ADDR_WIDTH  new fetch PC; bits [1:0] ignored (treated as 0)
- req_valid  out  1  memory read request valid
- req_ready  in  1  memory accepts request
- req_addr  out  ADDR_WIDTH  request address, word aligned
- rsp_valid  in  1  memory response valid
- rsp_ready  out  1  IFU accepts response
- rsp_data  in  DATA_WIDTH  fetched word
- rsp_err  in  1  access fault on this response
- out_valid  out  1  FIFO head valid to IDU
- out_ready  in  1  IDU consumes head
- out_pc  out  ADDR_WIDTH  PC of head entry
- out_inst  out  DATA_WIDTH  instruction of head entry
- out_err  out  1  head entry carries an access fault

Behaviour:
- Reset values:
  - state=REQ; fetch_pc=RESET_PC; FIFO empty.
  - req_valid=0, rsp_ready=0, out_valid=0.
  - out_pc/out_inst/out_err=0 while out_valid=0.
- Registered state: fetch_pc; 2-bit state {REQ, WAIT, DROP, HALT}; FIFO with count 0..BUF_DEPTH, entries {pc, inst, err}.
- Slot reservation: a request issues only if count < BUF_DEPTH. At most one request is outstanding, so an accepted response always has a free slot.
- REQ state:
  - req_valid = (count<BUF_DEPTH); req_addr = fetch_pc.
  - Once req_valid is high, req_valid and req_addr hold stable until req_ready, even if a redirect arrives.
  - On handshake: go to WAIT, or to DROP if redirect_valid is high in the same cycle.
- WAIT state:
  - rsp_ready=1.
  - On rsp_valid without redirect: push {fetch_pc, rsp_data, rsp_err}. fetch_pc <= fetch_pc+4, wrapping mod 2^ADDR_WIDTH. Next state is HALT if rsp_err, else REQ.
  - If redirect_valid arrives without rsp_valid: go to DROP.
  - If redirect_valid and rsp_valid arrive together: discard the response, go to REQ.
- DROP state: rsp_ready=1. Wait for rsp_valid, discard the data, go to REQ. Nothing is pushed.
- HALT state: no requests issued. Leave only on redirect (to REQ). The fault entry drains normally.
- Redirect (any state):
  - fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2],2'b00}.
  - FIFO flushed at the same edge: count=0, and out_valid=0 the next cycle.
  - An out_valid&out_ready handshake in the redirect cycle counts as consumed. A push in the redirect cycle is suppressed.
- FIFO:
  - Push and pop in the same cycle keep count unchanged.
  - Head is registered, so out_* change only at clock edges.
  - Pop only when out_valid&out_ready.
- Latency and throughput:
  - With req_ready=1 and a 1-cycle memory: request accepted in cycle N, response in N+1, out_valid in N+2.
  - Steady-state throughput is 1 instruction per 2 cycles.
- Reset mid-operation: all state returns to reset values at the next edge. A response arriving in the cycle after reset is ignored, since state is REQ and rsp_ready=0.
- rsp_valid in REQ or HALT is a protocol violation; it is ignored (rsp_ready=0).

Test Plan:
- Reset release, req_ready=rsp_valid=1 every cycle, out_ready=1 -> req_addr 8000_0000, 8000_0004, 8000_0008; out_pc follows two cycles after each request; out_inst matches rsp_data.
- out_ready=0 for 20 cycles -> exactly 4 entries buffered (BUF_DEPTH=4), req_valid drops to 0; raise out_ready -> 4 entries drain in order, then fetch resumes at 8000_0010.
- Redirect to 8000_0100 while in WAIT, response 3 cycles later -> stale word not pushed; next req_addr = 8000_0100; FIFO empty the cycle after the redirect.
- req_ready held 0 with redirect pulsed -> req_addr stays unchanged until accepted; response discarded; then req_addr = redirect target.
- rsp_err=1 on fetch of 8000_0008 -> entry emitted with out_err=1, no further requests; redirect to 8000_0200 -> fetch resumes.
- Redirect to FFFF_FFFC (ADDR_WIDTH=32) -> fetch FFFF_FFFC then 0000_0000; redirect_pc=8000_0003 -> req_addr 8000_0000.
